// File: rtl/gray_pkg.sv
// Shared Gray-code helpers and defaults for the counter, the downstream encoder stage and benches.
// The functions work on zero-extended values, so any width up to MAX_WIDTH uses them unchanged.
package gray_pkg;

    localparam int DEFAULT_WIDTH = 4;
    localparam int MAX_WIDTH     = 16;

    function automatic logic [MAX_WIDTH-1:0] bin2gray(input logic [MAX_WIDTH-1:0] x);
        return x ^ (x >> 1);
    endfunction

    // Prefix XOR from the MSB down; zero upper bits leave narrower codes unaffected.
    function automatic logic [MAX_WIDTH-1:0] gray2bin(input logic [MAX_WIDTH-1:0] g);
        logic [MAX_WIDTH-1:0] b;
        b[MAX_WIDTH-1] = g[MAX_WIDTH-1];
        for (int i = MAX_WIDTH - 2; i >= 0; i--) begin
            b[i] = b[i+1] ^ g[i];
        end
        return b;
    endfunction

endpackage

// File: rtl/gray_decoder.sv
// Combinational Gray-to-binary converter used on the counter's load path.
// Each binary bit is the XOR of all Gray bits at or above it, so there is no ripple chain.
module gray_decoder
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic [WIDTH-1:0] gray,
    output logic [WIDTH-1:0] bin
);

    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_prefix_xor
            assign bin[gi] = ^gray[WIDTH-1:gi];
        end
    endgenerate

endmodule

// File: rtl/gray_step_counter.sv
// Registered up/down binary counter with a registered Gray copy, wrap or saturate at the
// boundaries, terminal-count pulse and a Gray-coded reload path.
module gray_step_counter
    import gray_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH,
    parameter bit WRAP  = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_gray,
    output logic [WIDTH-1:0] bin_count,
    output logic [WIDTH-1:0] gray_count,
    output logic             tc,
    output logic             sat
);

    localparam logic [WIDTH-1:0] MAX_VAL = '1;

    logic [WIDTH-1:0] bin_reg, bin_next;
    logic [WIDTH-1:0] gray_reg, gray_next;
    logic [WIDTH-1:0] load_bin;
    logic             tc_reg, tc_next;
    logic             sat_reg, sat_next;
    logic             at_boundary;

    gray_decoder #(.WIDTH(WIDTH)) u_load_decoder (
        .gray (load_gray),
        .bin  (load_bin)
    );

    always_comb begin
        at_boundary = up ? (bin_reg == MAX_VAL) : (bin_reg == '0);
        bin_next    = bin_reg;
        tc_next     = 1'b0;
        sat_next    = sat_reg;

        if (load) begin
            bin_next = load_bin;
            sat_next = 1'b0;
        end else if (en) begin
            if (at_boundary) begin
                tc_next = 1'b1;
                if (WRAP) begin
                    bin_next = up ? '0 : MAX_VAL;
                    sat_next = 1'b0;
                end else begin
                    sat_next = 1'b1;
                end
            end else begin
                bin_next = up ? bin_reg + 1'b1 : bin_reg - 1'b1;
                sat_next = 1'b0;
            end
        end

        // Gray output always tracks the next binary value, including on load.
        gray_next = WIDTH'(bin2gray(MAX_WIDTH'(bin_next)));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bin_reg  <= '0;
            gray_reg <= '0;
            tc_reg   <= 1'b0;
            sat_reg  <= 1'b0;
        end else begin
            bin_reg  <= bin_next;
            gray_reg <= gray_next;
            tc_reg   <= tc_next;
            sat_reg  <= sat_next;
        end
    end

    assign bin_count  = bin_reg;
    assign gray_count = gray_reg;
    assign tc         = tc_reg;
    assign sat        = sat_reg;

endmodule

// File: tb/tb_gray_step_counter.sv
// Scoreboard bench: two counters (wrap and saturate) share one stimulus stream and are
// compared against an integer reference model every cycle.
module tb_gray_step_counter;

    localparam int W    = 4;
    localparam int MAXV = (1 << W) - 1;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         en = 1'b0, up = 1'b0, load = 1'b0;
    logic [W-1:0] load_gray = '0;

    logic [W-1:0] bin_w, gray_w, bin_s, gray_s;
    logic         tc_w, sat_w, tc_s, sat_s;

    always #5 clk = ~clk;

    gray_step_counter #(.WIDTH(W), .WRAP(1'b1)) u_wrap (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .bin_count(bin_w), .gray_count(gray_w), .tc(tc_w), .sat(sat_w)
    );

    gray_step_counter #(.WIDTH(W), .WRAP(1'b0)) u_sat (
        .clk(clk), .rst(rst), .en(en), .up(up), .load(load), .load_gray(load_gray),
        .bin_count(bin_s), .gray_count(gray_s), .tc(tc_s), .sat(sat_s)
    );

    typedef struct {
        int bw, gw, tw, sw;
        int bs, gs, ts, ss;
        bit stepped;
        int idx;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   txn   = 0;

    int m_cnt[2];
    int m_tc[2];
    int m_sat[2];

    // Reference decode: position of the code in the reflected Gray sequence.
    function automatic int gray_index(input int g);
        for (int i = 0; i <= MAXV; i++) begin
            if ((i ^ (i >> 1)) == g) return i;
        end
        return -1;
    endfunction

    task automatic check(input string name, input int idx, input int act, input int req);
        tests++;
        if (act != req) begin
            fails++;
            $display("FAIL txn %0d %s: got %0d, expected %0d", idx, name, act, req);
        end
    endtask

    task automatic drive(input bit r, input bit l, input int lg, input bit e, input bit u);
        exp_t it;
        int   code;
        @(negedge clk);
        code      = lg & MAXV;
        rst       = r;
        load      = l;
        load_gray = code[W-1:0];
        en        = e;
        up        = u;
        for (int m = 0; m < 2; m++) begin
            if (r) begin
                m_cnt[m] = 0; m_tc[m] = 0; m_sat[m] = 0;
            end else if (l) begin
                m_cnt[m] = gray_index(code); m_tc[m] = 0; m_sat[m] = 0;
            end else if (e) begin
                if ((u && m_cnt[m] == MAXV) || (!u && m_cnt[m] == 0)) begin
                    m_tc[m] = 1;
                    if (m == 0) m_cnt[m] = u ? 0 : MAXV;
                    else        m_sat[m] = 1;
                end else begin
                    m_cnt[m] = u ? m_cnt[m] + 1 : m_cnt[m] - 1;
                    m_tc[m]  = 0;
                    m_sat[m] = 0;
                end
            end else begin
                m_tc[m] = 0;
            end
        end
        it.bw = m_cnt[0]; it.gw = m_cnt[0] ^ (m_cnt[0] >> 1); it.tw = m_tc[0]; it.sw = m_sat[0];
        it.bs = m_cnt[1]; it.gs = m_cnt[1] ^ (m_cnt[1] >> 1); it.ts = m_tc[1]; it.ss = m_sat[1];
        it.stepped = !r && !l && e;
        it.idx     = txn++;
        sb.push_back(it);
    endtask

    // Monitor: outputs are valid every cycle, so one expectation is consumed per edge.
    initial begin : monitor
        exp_t         it;
        logic [W-1:0] prev_gray_w;
        bit           have_prev;
        have_prev = 1'b0;
        prev_gray_w = '0;
        forever begin
            @(posedge clk);
            #1;
            if (sb.size() > 0) begin
                it = sb.pop_front();
                check("wrap.bin",  it.idx, int'(bin_w),  it.bw);
                check("wrap.gray", it.idx, int'(gray_w), it.gw);
                check("wrap.tc",   it.idx, int'(tc_w),   it.tw);
                check("wrap.sat",  it.idx, int'(sat_w),  it.sw);
                check("sat.bin",   it.idx, int'(bin_s),  it.bs);
                check("sat.gray",  it.idx, int'(gray_s), it.gs);
                check("sat.tc",    it.idx, int'(tc_s),   it.ts);
                check("sat.sat",   it.idx, int'(sat_s),  it.ss);
                tests++;
                assert ((gray_w == (bin_w ^ (bin_w >> 1))) && (gray_s == (bin_s ^ (bin_s >> 1))))
                else begin
                    fails++;
                    $display("FAIL txn %0d gray_invariant: wrap %0d/%0d sat %0d/%0d (gray/bin)",
                             it.idx, gray_w, bin_w, gray_s, bin_s);
                end
                if (it.stepped && have_prev)
                    check("wrap.gray_1bit", it.idx, $countones(gray_w ^ prev_gray_w), 1);
                $display("[TB] txn %0d rst=%0b load=%0b en=%0b up=%0b | wrap bin=%0d gray=%b tc=%0b | sat bin=%0d tc=%0b sat=%0b",
                         it.idx, rst, load, en, up, bin_w, gray_w, tc_w, bin_s, tc_s, sat_s);
                prev_gray_w = gray_w;
                have_prev   = 1'b1;
            end
        end
    end

    initial begin : stimulus
        for (int m = 0; m < 2; m++) begin
            m_cnt[m] = 0; m_tc[m] = 0; m_sat[m] = 0;
        end
        drive(1, 0, 0, 0, 0);
        drive(1, 1, 5, 1, 1);
        // Full ramp through the wrap point.
        repeat (16) drive(0, 0, 0, 1, 1);
        // Seed at max, push into the upper boundary, then step back down.
        drive(0, 1, 4'b1000, 0, 0);
        repeat (3) drive(0, 0, 0, 1, 1);
        drive(0, 0, 0, 1, 0);
        // Load wins over a simultaneous step.
        drive(0, 1, 4'b0110, 1, 1);
        drive(0, 0, 0, 1, 0);
        // Downward boundary at zero.
        drive(0, 1, 4'b0000, 0, 0);
        drive(0, 0, 0, 1, 0);
        drive(0, 0, 0, 0, 0);
        drive(0, 0, 0, 1, 0);
        // Reset mid-run beats load and en.
        drive(0, 1, 4'b1101, 0, 0);
        drive(1, 1, 4'b0101, 1, 1);
        drive(0, 0, 0, 1, 1);
        // Direction flip every cycle from 7.
        drive(0, 1, 4'b0100, 0, 0);
        for (int i = 0; i < 4; i++) drive(0, 0, 0, 1, (i % 2) == 0);
        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 49) == 0, $urandom_range(0, 9) == 0,
                  int'($urandom_range(0, MAXV)), $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1);
        end
        drive(0, 0, 0, 0, 0);
        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
        tests++;
        if (sb.size() != 0) begin
            fails++;
            $display("FAIL drain: %0d expectations left, expected 0", sb.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
